// File: rtl/mem_arb_pkg.sv
// Shared defaults and types for the two-client memory request arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 32;

    typedef logic client_id_t;

    typedef struct packed {
        logic       valid;
        client_id_t id;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/mem_tag_pipe.sv
// Read-return tag delay line: shifts only on unpaused cycles and clears on reset.
module mem_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out
);

    tag_t tag_p [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tag_p[i] <= '0;
        end else if (!freeze) begin
            tag_p[0] <= tag_t'(tag_in);
            for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    assign tag_out = tag_p[DEPTH-1];

endmodule

// File: rtl/mem_request_arbiter.sv
// Two-client round-robin arbiter in front of a pipelined memory manager.
// Issues at most one registered request per unpaused cycle and routes read data back by tag.
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pause,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read
);

    logic              elig0;
    logic              elig1;
    logic              issue;
    client_id_t        grant_id;
    client_id_t        rr_prio;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    tag_t              tag_issue_p0;
    tag_t              tag_exit;
    logic [DATA_W-1:0] rdata_hold0;
    logic [DATA_W-1:0] rdata_hold1;

    // A client whose ack is up this cycle was already served for the request it still holds.
    always_comb begin
        elig0     = c0_req & ~c0_ack;
        elig1     = c1_req & ~c1_ack;
        issue     = ~pause & (elig0 | elig1);
        grant_id  = 1'b0;
        if (elig0 && elig1) grant_id = rr_prio;
        else if (elig1)     grant_id = 1'b1;
        sel_we    = grant_id ? c1_we    : c0_we;
        sel_addr  = grant_id ? c1_addr  : c0_addr;
        sel_wdata = grant_id ? c1_wdata : c0_wdata;
    end

    // Issue stage: registered request towards memory plus the read tag travelling with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_address        <= '0;
            mem_data_write     <= '0;
            mem_wren           <= 1'b0;
            c0_ack             <= 1'b0;
            c1_ack             <= 1'b0;
            rr_prio            <= 1'b0;
            tag_issue_p0       <= '0;
        end else if (pause) begin
            c0_ack <= 1'b0;
            c1_ack <= 1'b0;
        end else begin
            c0_ack <= issue & (grant_id == 1'b0);
            c1_ack <= issue & (grant_id == 1'b1);
            if (issue) begin
                mem_address        <= sel_addr;
                mem_data_write     <= sel_wdata;
                mem_wren           <= sel_we;
                tag_issue_p0.valid <= ~sel_we;
                tag_issue_p0.id    <= grant_id;
                rr_prio            <= ~grant_id;
            end else begin
                mem_wren     <= 1'b0;
                tag_issue_p0 <= '0;
            end
        end
    end

    mem_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .freeze  (pause),
        .tag_in  (tag_issue_p0),
        .tag_out (tag_exit)
    );

    // Return stage: a tag parked at the exit during pause fires on the first unpaused cycle.
    assign c0_rvalid = tag_exit.valid & ~pause & (tag_exit.id == 1'b0);
    assign c1_rvalid = tag_exit.valid & ~pause & (tag_exit.id == 1'b1);
    assign c0_rdata  = c0_rvalid ? mem_data_read : rdata_hold0;
    assign c1_rdata  = c1_rvalid ? mem_data_read : rdata_hold1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_hold0 <= '0;
            rdata_hold1 <= '0;
        end else begin
            if (c0_rvalid) rdata_hold0 <= mem_data_read;
            if (c1_rvalid) rdata_hold1 <= mem_data_read;
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench: three arbiters (read latency 2, 1, 8) share one directed stimulus stream.
module tb_mem_request_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int NDUT   = 3;
    localparam int LAT [NDUT] = '{2, 1, 8};

    typedef struct {
        int                cyc;
        logic              id;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pause;
    logic              c0_req, c0_we, c1_req, c1_we;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic [DATA_W-1:0] c0_wdata, c1_wdata;

    logic              c0_ack_w        [NDUT];
    logic              c1_ack_w        [NDUT];
    logic              c0_rvalid_w     [NDUT];
    logic              c1_rvalid_w     [NDUT];
    logic [DATA_W-1:0] c0_rdata_w      [NDUT];
    logic [DATA_W-1:0] c1_rdata_w      [NDUT];
    logic [ADDR_W-1:0] mem_address_w   [NDUT];
    logic              mem_wren_w      [NDUT];
    logic [DATA_W-1:0] mem_data_write_w[NDUT];
    logic [DATA_W-1:0] mem_data_read_w [NDUT];

    exp_t ack_q [NDUT][$];
    exp_t rv_q  [NDUT][$];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory manager model: returns {zero-extended address} of the read presented
    // LAT unpaused cycles earlier; all-ones when that slot was not a read.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = LAT[g];
        logic [ADDR_W:0] dl [L];

        always @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < L; i++) dl[i] <= '0;
            end else if (!pause) begin
                dl[0] <= {~mem_wren_w[g], mem_address_w[g]};
                for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
            end
        end

        assign mem_data_read_w[g] = dl[L-1][ADDR_W] ? DATA_W'(dl[L-1][ADDR_W-1:0]) : '1;

        mem_request_arbiter #(
            .ADDR_W       (ADDR_W),
            .DATA_W       (DATA_W),
            .READ_LATENCY (L)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .pause          (pause),
            .c0_req         (c0_req),
            .c0_we          (c0_we),
            .c0_addr        (c0_addr),
            .c0_wdata       (c0_wdata),
            .c0_ack         (c0_ack_w[g]),
            .c0_rvalid      (c0_rvalid_w[g]),
            .c0_rdata       (c0_rdata_w[g]),
            .c1_req         (c1_req),
            .c1_we          (c1_we),
            .c1_addr        (c1_addr),
            .c1_wdata       (c1_wdata),
            .c1_ack         (c1_ack_w[g]),
            .c1_rvalid      (c1_rvalid_w[g]),
            .c1_rdata       (c1_rdata_w[g]),
            .mem_address    (mem_address_w[g]),
            .mem_wren       (mem_wren_w[g]),
            .mem_data_write (mem_data_write_w[g]),
            .mem_data_read  (mem_data_read_w[g])
        );
    end

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d (latency %0d) cycle %0d: got 0x%0h, expected 0x%0h",
                     name, d, LAT[d], cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_ack(input logic id, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input int at);
        exp_t e;
        e.cyc = at; e.id = id; e.we = we; e.addr = addr; e.data = data;
        for (int d = 0; d < NDUT; d++) ack_q[d].push_back(e);
    endtask

    // Read return is due LAT unpaused cycles after the ack; stall adds the paused cycles in between.
    task automatic exp_rv(input logic id, input logic [DATA_W-1:0] data, input int ack_cyc, input int stall);
        exp_t e;
        e.id = id; e.we = 1'b0; e.addr = '0; e.data = data;
        for (int d = 0; d < NDUT; d++) begin
            e.cyc = ack_cyc + LAT[d] + stall;
            rv_q[d].push_back(e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk({tag, "_mem_address"},    d, mem_address_w[d], 0);
            chk({tag, "_mem_wren"},       d, mem_wren_w[d], 0);
            chk({tag, "_mem_data_write"}, d, mem_data_write_w[d], 0);
            chk({tag, "_acks"},           d, {c1_ack_w[d], c0_ack_w[d]}, 0);
            chk({tag, "_rvalids"},        d, {c1_rvalid_w[d], c0_rvalid_w[d]}, 0);
            chk({tag, "_c0_rdata"},       d, c0_rdata_w[d], 0);
            chk({tag, "_c1_rdata"},       d, c1_rdata_w[d], 0);
        end
    endtask

    // Monitor: every ack and rvalid pulse is matched against the head of its queue.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            exp_t e;
            if (c0_ack_w[d] || c1_ack_w[d]) begin
                if (ack_q[d].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack dut%0d cycle %0d: acks=%b, expected none",
                             d, cyc, {c1_ack_w[d], c0_ack_w[d]});
                end else begin
                    e = ack_q[d].pop_front();
                    chk("ack_cycle",   d, cyc, e.cyc);
                    chk("ack_client",  d, {c1_ack_w[d], c0_ack_w[d]}, e.id ? 2'b10 : 2'b01);
                    chk("mem_address", d, mem_address_w[d], e.addr);
                    chk("mem_wren",    d, mem_wren_w[d], e.we);
                    if (e.we) chk("mem_data_write", d, mem_data_write_w[d], e.data);
                end
            end
            if (c0_rvalid_w[d] || c1_rvalid_w[d]) begin
                if (rv_q[d].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rvalid dut%0d cycle %0d: rvalids=%b, expected none",
                             d, cyc, {c1_rvalid_w[d], c0_rvalid_w[d]});
                end else begin
                    e = rv_q[d].pop_front();
                    chk("rvalid_cycle",  d, cyc, e.cyc);
                    chk("rvalid_client", d, {c1_rvalid_w[d], c0_rvalid_w[d]}, e.id ? 2'b10 : 2'b01);
                    chk("rdata",         d, e.id ? c1_rdata_w[d] : c0_rdata_w[d], e.data);
                end
            end
        end
    end

    initial begin
        int base;
        rst_n = 1'b0; pause = 1'b0;
        c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
        tick(3);
        check_all_zero("reset");

        // c0 write right out of reset; req held 3 edges -> issues on edges 1 and 3 only.
        base = cyc;
        rst_n = 1'b1;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 18'h00010; c0_wdata = 32'hDEADBEEF;
        exp_ack(1'b0, 1'b1, 18'h00010, 32'hDEADBEEF, base + 1);
        exp_ack(1'b0, 1'b1, 18'h00010, 32'hDEADBEEF, base + 3);
        tick(3);
        c0_req = 1'b0;
        tick(2);
        for (int d = 0; d < NDUT; d++) begin
            chk("idle_wren",      d, mem_wren_w[d], 0);
            chk("idle_addr_hold", d, mem_address_w[d], 18'h00010);
            chk("idle_data_hold", d, mem_data_write_w[d], 32'hDEADBEEF);
        end

        // Both clients read continuously; c0 was granted last so c1 leads the alternation.
        base = cyc;
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 18'h1;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 18'h2;
        exp_ack(1'b1, 1'b0, 18'h2, '0, base + 1); exp_rv(1'b1, 32'h2, base + 1, 0);
        exp_ack(1'b0, 1'b0, 18'h1, '0, base + 2); exp_rv(1'b0, 32'h1, base + 2, 0);
        exp_ack(1'b1, 1'b0, 18'h2, '0, base + 3); exp_rv(1'b1, 32'h2, base + 3, 0);
        exp_ack(1'b0, 1'b0, 18'h1, '0, base + 4); exp_rv(1'b0, 32'h1, base + 4, 0);
        tick(4);
        c0_req = 1'b0; c1_req = 1'b0;
        tick(12);
        for (int d = 0; d < NDUT; d++) begin
            chk("c0_rdata_hold", d, c0_rdata_w[d], 32'h1);
            chk("c1_rdata_hold", d, c1_rdata_w[d], 32'h2);
        end

        // c1 read followed by three paused cycles: return slips by exactly three.
        base = cyc;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 18'h3;
        exp_ack(1'b1, 1'b0, 18'h3, '0, base + 1); exp_rv(1'b1, 32'h3, base + 1, 3);
        tick(1);
        c1_req = 1'b0; pause = 1'b1;
        tick(3);
        for (int d = 0; d < NDUT; d++) begin
            chk("pause_addr_hold", d, mem_address_w[d], 18'h3);
            chk("pause_wren_hold", d, mem_wren_w[d], 0);
            chk("pause_no_rvalid", d, {c1_rvalid_w[d], c0_rvalid_w[d]}, 0);
        end
        pause = 1'b0;
        tick(12);

        // c0 write requested while paused for 5 cycles; issued on first unpaused edge.
        base = cyc;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 18'h00020; c0_wdata = 32'h12345678; pause = 1'b1;
        exp_ack(1'b0, 1'b1, 18'h00020, 32'h12345678, base + 6);
        tick(5);
        for (int d = 0; d < NDUT; d++) chk("pending_addr_hold", d, mem_address_w[d], 18'h3);
        pause = 1'b0;
        tick(1);
        c0_req = 1'b0; pause = 1'b1;
        tick(2);
        for (int d = 0; d < NDUT; d++) begin
            chk("pause_wren_high_hold", d, mem_wren_w[d], 1);
            chk("pause_wr_addr_hold",   d, mem_address_w[d], 18'h00020);
        end
        pause = 1'b0;
        tick(1);
        for (int d = 0; d < NDUT; d++) chk("unpause_wren_low", d, mem_wren_w[d], 0);

        // Reset while a c0 read is in flight: no return, pointer back to c0.
        base = cyc;
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 18'h5;
        exp_ack(1'b0, 1'b0, 18'h5, '0, base + 1);
        tick(1);
        c0_req = 1'b0; rst_n = 1'b0;
        tick(1);
        check_all_zero("midread_reset");
        rst_n = 1'b1;
        c0_req = 1'b1; c0_addr = 18'h6;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 18'h7;
        exp_ack(1'b0, 1'b0, 18'h6, '0, base + 3); exp_rv(1'b0, 32'h6, base + 3, 0);
        exp_ack(1'b1, 1'b0, 18'h7, '0, base + 4); exp_rv(1'b1, 32'h7, base + 4, 0);
        tick(2);
        c0_req = 1'b0; c1_req = 1'b0;
        tick(12);

        for (int d = 0; d < NDUT; d++) begin
            chk("ack_q_drained", d, ack_q[d].size(), 0);
            chk("rv_q_drained",  d, rv_q[d].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_request_arbiter.md
MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 Parameter ADDR_W, 18, memory word address width.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter READ_LATENCY, 2, unpaused cycles from a read issue on mem_* to valid mem_data_read; legal range 1..8.
REQ-004 clk  in  1  single system clock, the same clock as the downstream memory manager.
REQ-005 rst_n  in  1  synchronous reset, active-low.
REQ-006 pause  in  1  stall from the memory manager; 1 = no new issue, all state frozen.
REQ-007 cN_req  in  1  (N = 0,1) client request, held until ack.
REQ-008 cN_we  in  1  1 = write, 0 = read.
REQ-009 cN_addr  in  ADDR_W  request address.
REQ-010 cN_wdata  in  DATA_W  write data.
REQ-011 cN_ack  out  1  one-cycle pulse: request accepted.
REQ-012 cN_rvalid  out  1  one-cycle pulse: cN_rdata valid.
REQ-013 cN_rdata  out  DATA_W  read return data.
REQ-014 mem_address  out  ADDR_W  address to the memory manager.
REQ-015 mem_wren  out  1  write enable to the memory manager.
REQ-016 mem_data_write  out  DATA_W  write data to the memory manager.
REQ-017 mem_data_read  in  DATA_W  read data from the memory manager.

Function
REQ-018 Issue cycle: pause=0 and at least one cN_req=1; at most one issue per cycle.
REQ-019 One requester: grant it. Both: grant the client not granted last (round-robin pointer), pointer updated on each issue.
REQ-020 Issue at edge t: at t+1, registered mem_address/mem_data_write = client fields, mem_wren = cN_we, cN_ack = 1 for exactly one cycle.
REQ-021 Non-issue unpaused cycle: mem_wren=0; mem_address, mem_data_write hold last values.
REQ-022 Requests with cN_ack=1 in the current cycle are ignored (no double issue); a client keeping req high gets its next issue no earlier than the cycle after ack.
REQ-023 Sustained two-client load: grants alternate 0,1,0,1..., one issue per unpaused cycle.
REQ-024 Read issue: tag {valid, client id} enters a READ_LATENCY-deep tag pipe; on exit, the tagged client's cN_rvalid=1 and cN_rdata=mem_data_read; the other client's rvalid=0.
REQ-025 Write issue: no tag, no rvalid.
REQ-026 pause=1: no issue, no ack; mem_* held including mem_wren; tag pipe and rvalid outputs frozen; rvalid pulses that would fall in paused cycles are emitted after pause falls, latency counting unpaused cycles only.
REQ-027 pause rising in the same cycle as a pending request: request not issued; issued on first unpaused cycle.
REQ-028 cN_rdata holds the last returned value between rvalid pulses.
REQ-029 Read-write ordering preserved: issue order equals mem_* presentation order; no reordering.

Reset
REQ-030 rst_n=0 at an edge: mem_address=0, mem_data_write=0, mem_wren=0, all ack/rvalid=0, cN_rdata=0, pointer favours client 0, tag pipe cleared.
REQ-031 Reset mid-read: in-flight tags discarded; no rvalid after reset release for pre-reset reads.
REQ-032 First issue possible on the first edge with rst_n=1.

Structure
REQ-033 Package mem_arb_pkg holds ADDR_W, DATA_W defaults, client-id typedef (1 bit), and tag struct {valid, id}.
REQ-034 Sub-module mem_tag_pipe: parameterised-depth tag shift register with freeze enable (pause) and synchronous clear.
REQ-035 Arbitration, issue registers, and return demux are in mem_request_arbiter.

Verification
REQ-036 c0 write addr 0x00010 data 0xDEADBEEF, pause=0 -> next cycle mem_wren=1, mem_address=0x00010, mem_data_write=0xDEADBEEF, c0_ack pulse; no rvalid.
REQ-037 Both req continuously, reads to 0x1/0x2, mem_data_read=address -> grants alternate c0,c1; c0_rvalid with 0x1 and c1_rvalid with 0x2, each READ_LATENCY cycles after its issue.
REQ-038 c1 read, pause=1 for 3 cycles after issue -> c1_rvalid delayed exactly 3 cycles; mem_* held during pause.
REQ-039 c0 req with pause=1 for 5 cycles -> no ack during pause; ack on first cycle after pause=0.
REQ-040 Read in flight, rst_n=0 one cycle -> all outputs 0, no rvalid after release, next grant goes to c0 on simultaneous req.
REQ-041 READ_LATENCY=1 and 8 builds -> rvalid timing matches parameter for back-to-back reads.
